// File: rtl/mips_pkg.sv
// Shared decode constants for the MIPS datapath core: ALU operations,
// opcode/funct encodings and architectural register indices.
package mips_pkg;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_XOR  = 3'b011,
    ALU_SLTU = 3'b100,
    ALU_LUI  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_V0   = 5'd2;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/mips_datapath_core_if.sv
// Bus-FSM <-> core signal bundle; master is the bus FSM, slave is the core.
// instr/pc/mem_rdata are held stable while wb_en is high; wb_en is a one-cycle
// strobe and the register write commits on the rising edge where it is high.
interface mips_datapath_core_if;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] mem_rdata;
  logic        wb_en;
  logic [31:0] alu_out;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic        branch_taken;
  logic        jump;
  logic [31:0] next_target;
  logic        invalid;
  logic [31:0] register_v0;

  modport master (
    output instr, pc, mem_rdata, wb_en,
    input  alu_out, store_data, mem_read, mem_write, branch_taken, jump,
           next_target, invalid, register_v0
  );

  modport slave (
    input  instr, pc, mem_rdata, wb_en,
    output alu_out, store_data, mem_read, mem_write, branch_taken, jump,
           next_target, invalid, register_v0
  );
endinterface

// File: rtl/mips_gpr_array.sv
// 32x32 general-purpose register file: two async read ports, one sync write
// port, sync reset, and a live tap of $v0.
module mips_gpr_array
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] v0_o
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != REG_ZERO)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // $0 is forced on read so it is zero even before the first reset.
  assign rdata_a_o = (raddr_a_i == REG_ZERO) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == REG_ZERO) ? '0 : regs_q[raddr_b_i];
  assign v0_o      = regs_q[REG_V0];

endmodule

// File: rtl/mips_datapath_core.sv
// Decode/control, ALU, immediate extension and next-PC target logic around the
// GPR array; everything except the register write is combinational.
module mips_datapath_core
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  mips_datapath_core_if.slave  bus
);

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  assign opcode = bus.instr[31:26];
  assign rs     = bus.instr[25:21];
  assign rt     = bus.instr[20:16];
  assign rd     = bus.instr[15:11];
  assign imm    = bus.instr[15:0];
  assign funct  = bus.instr[5:0];

  logic unused_shamt;
  assign unused_shamt = ^bus.instr[10:6];

  alu_op_e    alu_op;
  logic       use_imm, zero_ext, reg_write, link, is_lw, is_sw;
  logic       is_beq, is_bne, is_jump, jump_reg, illegal;
  logic [4:0] dest;

  always_comb begin
    alu_op    = ALU_ADD;
    use_imm   = 1'b0;
    zero_ext  = 1'b0;
    reg_write = 1'b0;
    link      = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_jump   = 1'b0;
    jump_reg  = 1'b0;
    illegal   = 1'b0;
    dest      = rd;
    case (opcode)
      OP_RTYPE: begin
        reg_write = 1'b1;
        case (funct)
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_JR: begin
            reg_write = 1'b0;
            is_jump   = 1'b1;
            jump_reg  = 1'b1;
          end
          FN_JALR: begin
            is_jump  = 1'b1;
            jump_reg = 1'b1;
            link     = 1'b1;
          end
          default: begin
            reg_write = 1'b0;
            illegal   = 1'b1;
          end
        endcase
      end
      OP_J:     is_jump = 1'b1;
      OP_JAL: begin
        is_jump   = 1'b1;
        link      = 1'b1;
        reg_write = 1'b1;
        dest      = REG_RA;
      end
      OP_BEQ: begin alu_op = ALU_SUB; is_beq = 1'b1; end
      OP_BNE: begin alu_op = ALU_SUB; is_bne = 1'b1; end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
        use_imm   = 1'b1;
        reg_write = 1'b1;
        dest      = rt;
        case (opcode)
          OP_SLTI:  alu_op = ALU_SLT;
          OP_SLTIU: alu_op = ALU_SLTU;
          OP_ANDI:  begin alu_op = ALU_AND; zero_ext = 1'b1; end
          OP_ORI:   begin alu_op = ALU_OR;  zero_ext = 1'b1; end
          OP_XORI:  begin alu_op = ALU_XOR; zero_ext = 1'b1; end
          OP_LUI:   alu_op = ALU_LUI;
          OP_LW:    is_lw  = 1'b1;
          default:  alu_op = ALU_ADD;
        endcase
      end
      OP_SW: begin use_imm = 1'b1; is_sw = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

  logic [31:0] rs_data, rt_data, imm_ext, alu_b, alu_result, wb_data;
  logic [31:0] pc_plus4;

  assign imm_ext  = zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  assign alu_b    = use_imm ? imm_ext : rt_data;
  assign pc_plus4 = bus.pc + 32'd4;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_AND:  alu_result = rs_data & alu_b;
      ALU_OR:   alu_result = rs_data | alu_b;
      ALU_ADD:  alu_result = rs_data + alu_b;
      ALU_XOR:  alu_result = rs_data ^ alu_b;
      ALU_SLTU: alu_result = {31'd0, rs_data < alu_b};
      ALU_LUI:  alu_result = {alu_b[15:0], 16'h0000};
      ALU_SUB:  alu_result = rs_data - alu_b;
      ALU_SLT:  alu_result = {31'd0, $signed(rs_data) < $signed(alu_b)};
      default:  alu_result = '0;
    endcase
  end

  // Link writes use pc+8 (the instruction after the delay slot).
  assign wb_data = link ? (bus.pc + 32'd8) : (is_lw ? bus.mem_rdata : alu_result);

  mips_gpr_array u_gpr (
    .clk       (clk),
    .reset     (reset),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rs_data),
    .rdata_b_o (rt_data),
    .we_i      (bus.wb_en && reg_write),
    .waddr_i   (dest),
    .wdata_i   (wb_data),
    .v0_o      (bus.register_v0)
  );

  assign bus.alu_out      = alu_result;
  assign bus.store_data   = rt_data;
  assign bus.mem_read     = is_lw;
  assign bus.mem_write    = is_sw;
  assign bus.branch_taken = (is_beq && (alu_result == '0)) || (is_bne && (alu_result != '0));
  assign bus.jump         = is_jump;
  assign bus.invalid      = illegal;
  assign bus.next_target  = jump_reg ? rs_data :
                            is_jump  ? {pc_plus4[31:28], bus.instr[25:0], 2'b00} :
                                       (pc_plus4 + {imm_ext[29:0], 2'b00});

endmodule

// File: tb/tb_mips_datapath_core.sv
// Directed-vector bench for mips_datapath_core with hand-computed expectations.
module tb_mips_datapath_core;

  logic clk;
  logic reset;
  int   n_compared;
  int   n_mismatched;

  mips_datapath_core_if bus ();

  mips_datapath_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic load(input logic [31:0] ins);
    bus.instr = ins;
    #1;
  endtask

  task automatic commit(input logic [31:0] rdata);
    bus.mem_rdata = rdata;
    bus.wb_en     = 1'b1;
    @(posedge clk);
    #1;
    bus.wb_en     = 1'b0;
  endtask

  task automatic exec(input logic [31:0] ins);
    load(ins);
    commit(32'h0);
  endtask

  initial begin
    n_compared    = 0;
    n_mismatched  = 0;
    reset         = 1'b1;
    bus.instr     = 32'h0;
    bus.pc        = 32'h0;
    bus.mem_rdata = 32'h0;
    bus.wb_en     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("reset_v0", bus.register_v0, 32'h0);

    // ORI $2,$0,0x1234
    exec(enc_i(6'h0D, 5'd0, 5'd2, 16'h1234));
    check_eq("ori_v0", bus.register_v0, 32'h0000_1234);

    // reset at the same edge as a write-back: reset wins
    load(enc_i(6'h0D, 5'd0, 5'd2, 16'h0077));
    reset     = 1'b1;
    bus.wb_en = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    bus.wb_en = 1'b0;
    check_eq("reset_over_wb", bus.register_v0, 32'h0);

    // LUI/ORI/ADDU/SUBU
    exec(enc_i(6'h0F, 5'd0, 5'd3, 16'hFFFF));
    exec(enc_i(6'h0D, 5'd3, 5'd3, 16'h0001));
    exec(enc_r(5'd3, 5'd3, 5'd2, 6'h21));
    check_eq("addu_v0", bus.register_v0, 32'hFFFE_0002);
    check_eq("addu_valid", {31'd0, bus.invalid}, 32'd0);
    exec(enc_r(5'd0, 5'd3, 5'd2, 6'h23));
    check_eq("subu_v0", bus.register_v0, 32'h0000_FFFF);

    // no bypass: reads during the write-back cycle see the old value
    exec(enc_i(6'h0D, 5'd0, 5'd2, 16'h0005));
    load(enc_i(6'h09, 5'd2, 5'd2, 16'h0001));
    check_eq("addiu_pre", bus.alu_out, 32'd6);
    bus.wb_en = 1'b1;
    #1;
    check_eq("addiu_wb_cycle", bus.alu_out, 32'd6);
    @(posedge clk);
    #1;
    bus.wb_en = 1'b0;
    check_eq("addiu_v0", bus.register_v0, 32'd6);
    check_eq("addiu_post", bus.alu_out, 32'd7);

    // SLT / SLTU with $4=-1, $5=1
    exec(enc_i(6'h09, 5'd0, 5'd4, 16'hFFFF));
    exec(enc_i(6'h09, 5'd0, 5'd5, 16'h0001));
    exec(enc_r(5'd4, 5'd5, 5'd2, 6'h2A));
    check_eq("slt_v0", bus.register_v0, 32'd1);
    exec(enc_r(5'd4, 5'd5, 5'd2, 6'h2B));
    check_eq("sltu_v0", bus.register_v0, 32'd0);
    exec(enc_i(6'h09, 5'd0, 5'd2, 16'hFFFF));
    check_eq("addiu_neg_v0", bus.register_v0, 32'hFFFF_FFFF);

    // zero-extended logical immediates and immediate compares
    exec(enc_i(6'h0C, 5'd4, 5'd2, 16'h8001));
    check_eq("andi_v0", bus.register_v0, 32'h0000_8001);
    exec(enc_i(6'h0E, 5'd0, 5'd2, 16'hFFFF));
    check_eq("xori_v0", bus.register_v0, 32'h0000_FFFF);
    exec(enc_i(6'h0A, 5'd5, 5'd2, 16'hFFFF));
    check_eq("slti_v0", bus.register_v0, 32'd0);
    exec(enc_i(6'h0B, 5'd5, 5'd2, 16'hFFFF));
    check_eq("sltiu_v0", bus.register_v0, 32'd1);

    // LW $2,8($6) with $6=0x100
    exec(enc_i(6'h0D, 5'd0, 5'd6, 16'h0100));
    load(enc_i(6'h23, 5'd6, 5'd2, 16'h0008));
    check_eq("lw_mem_read", {31'd0, bus.mem_read}, 32'd1);
    check_eq("lw_addr", bus.alu_out, 32'h0000_0108);
    commit(32'hDEAD_BEEF);
    check_eq("lw_v0", bus.register_v0, 32'hDEAD_BEEF);

    // SW $2,4($6)
    load(enc_i(6'h2B, 5'd6, 5'd2, 16'h0004));
    check_eq("sw_strobes", {30'd0, bus.mem_write, bus.mem_read}, 32'b10);
    check_eq("sw_data", bus.store_data, 32'hDEAD_BEEF);
    check_eq("sw_addr", bus.alu_out, 32'h0000_0104);
    commit(32'h1111_1111);
    check_eq("sw_no_write", bus.register_v0, 32'hDEAD_BEEF);

    // branches and jumps at pc=0xBFC00000
    bus.pc = 32'hBFC0_0000;
    load(enc_i(6'h04, 5'd4, 5'd4, 16'hFFFF));
    check_eq("beq_taken", {31'd0, bus.branch_taken}, 32'd1);
    check_eq("beq_target", bus.next_target, 32'hBFC0_0000);
    check_eq("beq_no_jump", {31'd0, bus.jump}, 32'd0);
    load(enc_i(6'h05, 5'd4, 5'd4, 16'hFFFF));
    check_eq("bne_eq_not_taken", {31'd0, bus.branch_taken}, 32'd0);
    load(enc_i(6'h05, 5'd4, 5'd5, 16'h0003));
    check_eq("bne_taken", {31'd0, bus.branch_taken}, 32'd1);
    check_eq("bne_target", bus.next_target, 32'hBFC0_0010);
    load(enc_i(6'h04, 5'd4, 5'd5, 16'h0003));
    check_eq("beq_ne_not_taken", {31'd0, bus.branch_taken}, 32'd0);

    load(enc_j(6'h03, 26'h000_0010));
    check_eq("jal_jump", {31'd0, bus.jump}, 32'd1);
    check_eq("jal_target", bus.next_target, 32'hB000_0040);
    commit(32'h0);
    load(enc_r(5'd31, 5'd0, 5'd0, 6'h08));
    check_eq("jr_jump", {31'd0, bus.jump}, 32'd1);
    check_eq("jr_target_ra", bus.next_target, 32'hBFC0_0008);
    commit(32'h0);
    check_eq("jr_no_write", bus.register_v0, 32'hDEAD_BEEF);

    // JALR $2,$6 at pc=0x1000
    bus.pc = 32'h0000_1000;
    load(enc_r(5'd6, 5'd0, 5'd2, 6'h09));
    check_eq("jalr_target", bus.next_target, 32'h0000_0100);
    commit(32'h0);
    check_eq("jalr_link_v0", bus.register_v0, 32'h0000_1008);

    // writes to $0 are discarded
    exec(enc_i(6'h0D, 5'd0, 5'd0, 16'h0055));
    load(enc_r(5'd0, 5'd0, 5'd7, 6'h25));
    check_eq("zero_reg_read", bus.alu_out, 32'h0);

    // unknown opcode and unknown funct
    load(enc_i(6'h3F, 5'd0, 5'd2, 16'h1234));
    check_eq("bad_op_invalid", {31'd0, bus.invalid}, 32'd1);
    check_eq("bad_op_strobes",
             {28'd0, bus.mem_read, bus.mem_write, bus.jump, bus.branch_taken}, 32'd0);
    commit(32'h5555_5555);
    check_eq("bad_op_no_write", bus.register_v0, 32'h0000_1008);
    load(enc_r(5'd0, 5'd0, 5'd2, 6'h3F));
    check_eq("bad_fn_invalid", {31'd0, bus.invalid}, 32'd1);
    commit(32'h0);
    check_eq("bad_fn_no_write", bus.register_v0, 32'h0000_1008);

    // plain reset clears $v0
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("final_reset_v0", bus.register_v0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mips_datapath_core.md
# mips_datapath_core

Single-cycle-decode execution core for the multi-cycle MIPS bus CPU. It combines instruction decode/control, a 32x32 general-purpose register file and the ALU. The bus FSM supplies the fetched instruction, PC and load data, and pulses write-back. The core returns memory address/data, control strobes, next-PC information and `$v0`.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all registers.
- instr  in  32  current instruction, held stable by the FSM from fetch through write-back.
- pc  in  32  address of `instr`.
- mem_rdata  in  32  load data, valid when `wb_en` is asserted for LW.
- wb_en  in  1  one-cycle write-back strobe; the register write is committed on this edge.
- alu_out  out  32  ALU result; also the memory address for LW/SW.
- store_data  out  32  rt register value (SW write data).
- mem_read  out  1  instruction is LW.
- mem_write  out  1  instruction is SW.
- branch_taken  out  1  BEQ/BNE whose condition holds.
- jump  out  1  J, JAL, JR or JALR.
- next_target  out  32  branch or jump destination; meaningful only when `branch_taken|jump`.
- invalid  out  1  opcode/funct not in the supported set.
- register_v0  out  32  live value of `$2`.

## Operation
- Fields: rs=instr[25:21], rt=instr[20:16], rd=instr[15:11], imm=instr[15:0], funct=instr[5:0], opcode=instr[31:26].
- Supported R-type (opcode 0), by funct:
  - ADDU 0x21, SUBU 0x23, AND 0x24, OR 0x25, XOR 0x26, SLT 0x2A, SLTU 0x2B: write rd.
  - JR 0x08: no register write.
  - JALR 0x09: writes pc+8 to rd.
- Supported I/J-type, by opcode:
  - ADDIU 0x09, SLTI 0x0A, SLTIU 0x0B, ANDI 0x0C, ORI 0x0D, XORI 0x0E, LUI 0x0F: write rt.
  - LW 0x23: writes rt from `mem_rdata`.
  - SW 0x2B: no register write.
  - BEQ 0x04, BNE 0x05: no register write.
  - J 0x02: no register write.
  - JAL 0x03: writes pc+8 to `$31`.
- Immediate extension:
  - ANDI/ORI/XORI zero-extend.
  - All other immediates sign-extend.
- ALU ops (3-bit), result computed from A=rs_data and B=rt_data or extended imm:
  - 000 AND, 001 OR, 010 ADD (mod 2^32), 011 XOR.
  - 100 SLTU (unsigned compare, result 0/1).
  - 101 LUI (B<<16).
  - 110 SUB (mod 2^32).
  - 111 SLT (signed compare, result 0/1).
- LW/SW use ADD; the address is rs+sext(imm).
- BEQ/BNE use SUB and an internal zero flag (alu_out==0).
  - BEQ: branch_taken=zero.
  - BNE: branch_taken=!zero.
- Targets:
  - Branch: pc+4+(sext(imm)<<2).
  - J/JAL: {pc+4[31:28], instr[25:0], 2'b00}.
  - JR/JALR: rs_data.
- Write-back data mux: link → pc+8; LW → mem_rdata; otherwise alu_out.
- Invalid instruction:
  - All strobes low, no register write.
  - ALU op ADD.
  - invalid=1.
- No arithmetic overflow trapping.

## Timing
- Decode, ALU, targets and register reads are purely combinational from `instr`, `pc` and register contents; latency 0.
- Register write occurs at the rising edge where wb_en=1 and the instruction writes a register.
- Writes to `$0` are discarded; `$0` always reads 0.
- Reads in the write-back cycle return the old value (no bypass). The new value is visible in the cycle after the edge.
- reset=1 at a rising edge clears all 32 registers, overriding a simultaneous wb_en.
- After reset, register_v0=0. Combinational outputs follow `instr` and are not forced by reset.
- Before the first reset, register contents are undefined.
- A reset asserted mid-instruction loses any pending write-back.

## Structure
- Package `mips_pkg`: ALU-op enum, opcode and funct localparams, register index constants (`$0`, `$2`, `$31`).
- One sub-module, `mips_gpr_array`: 32x32, two asynchronous read ports, one synchronous write port, sync reset, `$2` tap.
- Decode, ALU, extension and target logic live inline in the top module.

## Test plan
- Reset, then ORI $2,$0,0x1234 with wb_en pulse → register_v0=0x00001234. Then assert reset → register_v0=0.
- LUI $3,0xFFFF; ORI $3,$3,0x0001; ADDU $2,$3,$3 → register_v0=0xFFFE0002. Also SUBU $2,$0,$3 → 0x0000FFFF.
- SLT/SLTU with $4=0xFFFFFFFF, $5=1:
  - SLT $2,$4,$5 → 1.
  - SLTU $2,$4,$5 → 0.
  - ADDIU $2,$0,-1 → 0xFFFFFFFF (sign-extended).
- LW $2,8($6) with $6=0x100, mem_rdata=0xDEADBEEF → mem_read=1, alu_out=0x108, register_v0=0xDEADBEEF. SW → mem_write=1, store_data=rt value, no register change.
- Branches and jumps at pc=0xBFC00000:
  - BEQ with equal regs, imm=0xFFFF → branch_taken=1, next_target=0xBFC00000.
  - BNE with equal regs → branch_taken=0.
  - JAL 0x0000010 → next_target=0xB0000040, `$31`=0xBFC00008.
- Write to `$0`, then read → 0. Unknown opcode 0x3F → invalid=1, no strobes, registers unchanged.
